// File: rtl/pipelined_rca_if.sv
// Valid/ready bundle carrying operands into, and results out of, pipelined_rca.
interface pipelined_rca_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple per register stage,
// all stages advancing together under a single valid/ready flow-control enable.
module pipelined_rca #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input logic          clk,
    input logic          rst,
    pipelined_rca_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    logic adv;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage k resolves chunk k; it carries only the still-unresolved operand bits
    // forward and grows the resolved sum by one chunk, so register widths taper.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * CHUNK;
        localparam int SW = (k + 1) * CHUNK;

        logic [IW-1:0]    a_s;
        logic [IW-1:0]    b_s;
        logic             c_s;
        logic             v_s;
        logic [CHUNK-1:0] chunk_sum;
        logic             c_n;
        logic [SW-1:0]    sum_n;

        logic             v_q;
        logic             c_q;
        logic [SW-1:0]    sum_q;

        if (k == 0) begin : g_src
            assign a_s   = bus.A;
            assign b_s   = bus.Sub ? ~bus.B : bus.B;
            assign c_s   = bus.Sub | bus.Cin;
            assign v_s   = bus.in_valid;
            assign sum_n = chunk_sum;
        end else begin : g_src
            assign a_s   = g_stage[k-1].g_fwd.a_q;
            assign b_s   = g_stage[k-1].g_fwd.b_q;
            assign c_s   = g_stage[k-1].c_q;
            assign v_s   = g_stage[k-1].v_q;
            assign sum_n = {chunk_sum, g_stage[k-1].sum_q};
        end

        always_comb begin
            chunk_sum = '0;
            c_n       = c_s;
            for (int i = 0; i < CHUNK; i++) begin
                chunk_sum[i] = a_s[i] ^ b_s[i] ^ c_n;
                c_n          = (a_s[i] & b_s[i]) | (c_n & (a_s[i] ^ b_s[i]));
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_s;
                c_q   <= c_n;
                sum_q <= sum_n;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IW-CHUNK-1:0] a_q;
            logic [IW-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_s[IW-1:CHUNK];
                    b_q <= b_s[IW-1:CHUNK];
                end
            end
        end

        // Carry into the MSB is recovered as a^b^sum at that bit, avoiding a tap mid-chain.
        if (k == STAGES - 1) begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ c_n;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.Sum       = g_stage[STAGES-1].sum_q;
    assign bus.Cout      = g_stage[STAGES-1].c_q;
    assign bus.Ovf       = g_stage[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: a 32-bit/4-bit-chunk instance driven through directed,
// random streaming, stall and reset scenarios, plus a single-stage 8-bit instance.
module tb_pipelined_rca;
    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic [33:0] sb[$];
    int          n_acc;
    int          n_out;
    int          cyc;
    int          last_out_cyc;
    bit          last_acc;
    bit          check_gap;

    pipelined_rca_if #(.WIDTH(32)) if32 ();
    pipelined_rca_if #(.WIDTH(8))  if8 ();

    pipelined_rca #(.WIDTH(32), .CHUNK(4)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32)
    );

    pipelined_rca #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain wide arithmetic; overflow from operand/result signs.
    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        logic [31:0] bb;
        logic        c;
        logic [32:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        c    = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, c};
        ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        return {ovf, full[32], full[31:0]};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input bit valid, input bit ready);
        if (!if32.in_valid || last_acc) begin
            if32.A   = $urandom;
            if32.B   = $urandom;
            if32.Cin = 1'($urandom_range(0, 1));
            if32.Sub = 1'($urandom_range(0, 1));
        end
        if32.in_valid  = valid;
        if32.out_ready = ready;
    endtask

    // Called at the negedge: records handshakes that the next rising edge will complete.
    task automatic sb_sample();
        logic [33:0] exp;
        if (if32.out_valid && if32.out_ready) begin
            check_output("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check_output("stream_result", {30'd0, if32.Ovf, if32.Cout, if32.Sum}, {30'd0, exp});
                if (check_gap && n_out > 0)
                    check_output("stream_gap", 64'(cyc - last_out_cyc), 64'd1);
                last_out_cyc = cyc;
                n_out++;
            end
        end
        if (if32.in_valid && if32.in_ready) begin
            sb.push_back(model32(if32.A, if32.B, if32.Cin, if32.Sub));
            n_acc++;
            last_acc = 1'b1;
        end else begin
            last_acc = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [31:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
        int lat;
        if32.A         = a;
        if32.B         = b;
        if32.Cin       = cin;
        if32.Sub       = sub;
        if32.in_valid  = 1'b1;
        if32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if32.in_valid = 1'b0;
        lat = 0;
        while (!if32.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output({tag, "_latency"}, 64'(lat), 64'd7);
        check_output({tag, "_sum"}, 64'(if32.Sum), 64'(exp_sum));
        check_output({tag, "_cout"}, 64'(if32.Cout), 64'(exp_cout));
        check_output({tag, "_ovf"}, 64'(if32.Ovf), 64'(exp_ovf));
        @(posedge clk);
        #1;
    endtask

    task automatic do_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input logic [7:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        int lat;
        if8.A         = a;
        if8.B         = b;
        if8.Cin       = cin;
        if8.Sub       = sub;
        if8.in_valid  = 1'b1;
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output({tag, "_latency"}, 64'(lat), 64'd0);
        check_output({tag, "_sum"}, 64'(if8.Sum), 64'(exp_sum));
        check_output({tag, "_cout"}, 64'(if8.Cout), 64'(exp_cout));
        check_output({tag, "_ovf"}, 64'(if8.Ovf), 64'(exp_ovf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst            = 1'b1;
        if32.in_valid  = 1'b0;
        if32.A         = '0;
        if32.B         = '0;
        if32.Cin       = 1'b0;
        if32.Sub       = 1'b0;
        if32.out_ready = 1'b0;
        if8.in_valid   = 1'b0;
        if8.A          = '0;
        if8.B          = '0;
        if8.Cin        = 1'b0;
        if8.Sub        = 1'b0;
        if8.out_ready  = 1'b1;
        n_acc          = 0;
        n_out          = 0;
        cyc            = 0;
        last_out_cyc   = 0;
        last_acc       = 1'b0;
        check_gap      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_out_valid", 64'(if32.out_valid), 64'd0);
        check_output("rst_sum", 64'(if32.Sum), 64'd0);
        check_output("rst_in_ready", 64'(if32.in_ready), 64'd1);
        check_output("rst8_out_valid", 64'(if8.out_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("idle_ready_ignores_out_ready", 64'(if32.in_ready), 64'd1);

        $display("[TB] directed add/sub");
        do_op32("wrap_add", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        do_op32("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op32("sub_5_7_cin", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op32("sub_min_1", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op32("sub_min_1_cin", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op32("add_pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        $display("[TB] random back-to-back stream");
        check_gap = 1'b1;
        n_acc = 0;
        n_out = 0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b1);
            @(negedge clk);
            check_output("stream_in_ready", 64'(if32.in_ready), 64'd1);
            sb_sample();
            @(posedge clk);
            #1;
            cyc++;
        end
        t = 0;
        while (sb.size() > 0 && t < 40) begin
            apply_stimulus(1'b0, 1'b1);
            tick();
            t++;
        end
        check_output("stream_count", 64'(n_out), 64'd16);
        check_gap = 1'b0;

        $display("[TB] backpressure stall");
        n_acc = 0;
        n_out = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0);
            @(negedge clk);
            check_output("stall_in_ready", 64'(if32.in_ready), 64'd0);
            check_output("stall_out_valid", 64'(if32.out_valid), 64'd1);
            check_output("stall_held", {30'd0, if32.Ovf, if32.Cout, if32.Sum}, {30'd0, sb[0]});
            sb_sample();
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1);
            tick();
        end
        t = 0;
        while (sb.size() > 0 && t < 40) begin
            apply_stimulus(1'b0, 1'b1);
            tick();
            t++;
        end
        check_output("stall_drained", 64'(sb.size()), 64'd0);
        check_output("stall_count", 64'(n_out), 64'(n_acc));

        $display("[TB] reset with operations in flight");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1);
            tick();
        end
        if32.in_valid = 1'b1;
        if32.A        = 32'h11;
        if32.B        = 32'h22;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        if32.in_valid = 1'b0;
        sb.delete();
        check_output("post_rst_out_valid", 64'(if32.out_valid), 64'd0);
        check_output("post_rst_sum", 64'(if32.Sum), 64'd0);
        check_output("post_rst_in_ready", 64'(if32.in_ready), 64'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_output("no_stale_out", 64'(if32.out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        do_op32("after_rst", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);

        $display("[TB] single-stage 8-bit instance");
        do_op8("w8_pos_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op8("w8_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op8("w8_sub", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor. It splits a WIDTH-bit operation into WIDTH/CHUNK ripple chunks with one register stage per chunk, so clock frequency scales with CHUNK rather than WIDTH. Operands are accepted through a valid/ready handshake and results leave through one, so the block drops into streaming datapaths as the generalised replacement for fixed-width combinational RCA chains.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (≥1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts operand this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in (add mode only).
- Sub  in  1  0: A+B+Cin; 1: A−B (A + ~B + 1, Cin ignored).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- Sum  out  WIDTH  result.
- Cout  out  1  raw carry out of bit WIDTH−1.
- Ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Global advance enable: adv = !out_valid || out_ready. All stages shift together when adv=1; the whole pipeline holds when adv=0.
- in_ready = adv (combinational from out_valid/out_ready; no dependency on in_valid).
- Accept: in_valid && in_ready. Stage 0 captures A, B' = Sub ? ~B : B, and c0 = Sub ? 1 : Cin, then resolves bits [CHUNK−1:0].
- Stage k (1..STAGES−1) adds chunk k of its registered A/B' with the registered carry from stage k−1 and appends its sum chunk to the registered lower sum bits. Unresolved upper operand chunks travel forward unchanged (input skew); resolved lower chunks travel forward unchanged (output deskew).
- Each stage has a valid bit; a bubble (no accept while adv=1) shifts in valid=0. Results leave strictly in acceptance order, one per cycle maximum.
- Final stage registers Sum, Cout, and Ovf (carry into MSB is the internal carry of the top chunk at bit WIDTH−2→WIDTH−1).
- Arithmetic modulo 2^WIDTH; no saturation. Cout is meaningful for unsigned, Ovf for two's-complement; both are always driven.
- Stalled outputs (out_valid=1, out_ready=0) hold Sum/Cout/Ovf stable until accepted.

## Timing
- Latency: result for an operand accepted at edge N has out_valid=1 after edge N+STAGES−1, i.e. visible STAGES cycles after the accept cycle when no stall occurs. Each cycle of adv=0 adds one cycle.
- Throughput: 1 op/cycle with out_ready held high.
- STAGES=1: single register stage, latency 1, pure registered adder with handshake.
- Reset (rst=1 at an edge): all stage valid bits, out_valid, Sum, Cout, Ovf and internal data registers → 0. in_ready reads 1 during and after reset (out_valid=0). In-flight operations are discarded; none reappear after reset. Reset overrides simultaneous accept.
- Simultaneous out accept and in accept in a full pipeline: both occur in the same cycle; no bubble, no loss.
- out_ready toggling while out_valid=0: no effect.

## Test plan
- WIDTH=32, CHUNK=4: A=0xFFFFFFFF, B=0, Cin=1, Sub=0 → Sum=0x00000000, Cout=1, Ovf=0, out_valid exactly 8 cycles after the accept cycle.
- Subtract: A=5, B=7, Sub=1 → Sum=0xFFFFFFFE, Cout=0, Ovf=0; A=0x80000000, B=1, Sub=1 → Sum=0x7FFFFFFF, Cout=1, Ovf=1; Cin=1 in either case changes nothing.
- Stream 16 random operands back-to-back with out_ready=1 → 16 results on consecutive cycles, in order, all matching the reference model, in_ready constantly 1.
- Fill the pipeline, then drop out_ready for 5 cycles while in_valid=1 → in_ready=0 for those 5 cycles, Sum/Cout/Ovf held constant, and after release all results arrive exactly once in order.
- Assert rst for 1 cycle with 4 ops in flight → out_valid=0 and Sum=0 the next cycle, no stale results ever emitted; a following op A=1, B=2 yields Sum=3 after 8 cycles.
- WIDTH=8, CHUNK=8 (STAGES=1): A=0x7F, B=0x01 → Sum=0x80, Ovf=1, Cout=0 after 1 cycle; A=0xFF, B=0x01 → Sum=0x00, Cout=1, Ovf=0.
